// File: rtl/register_write_arbiter.sv
// Register-file write-port arbiter: picks one requester per cycle and issues its write for one cycle.
// Define REGWRITE_ARB_RR_EN for round-robin selection; otherwise the lowest index has fixed priority.
module register_write_arbiter #(
  parameter int P_RegWidth   = 3,
  parameter int P_DataWidth  = 8,
  parameter int P_Requesters = 4
) (
  input  logic                              In_Clock,
  input  logic                              In_Reset,
  input  logic [P_Requesters-1:0]           In_Request,
  input  logic [P_Requesters*P_RegWidth-1:0]  In_Address,
  input  logic [P_Requesters*P_DataWidth-1:0] In_Data,
  output logic [P_Requesters-1:0]           Out_Grant,
  output logic [P_RegWidth-1:0]             Out_Address,
  output logic                              Out_Enable,
  output logic [P_DataWidth-1:0]            Out_Data,
  output logic                              Out_Busy
);

  localparam int PtrW = $clog2(P_Requesters);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                  state;
  logic [P_Requesters-1:0] eligible;
  logic [P_Requesters-1:0] win_onehot;
  logic [PtrW-1:0]         winner;
  logic [P_RegWidth-1:0]   win_addr;
  logic [P_DataWidth-1:0]  win_data;

  // The requester being written this cycle sits out one arbitration round.
  always_comb begin
    eligible = (state == WRITE) ? (In_Request & ~Out_Grant) : In_Request;
  end

`ifdef REGWRITE_ARB_RR_EN
  logic [PtrW-1:0]         ptr;
  logic [PtrW-1:0]         ptr_next;
  logic [PtrW-1:0]         offset;
  logic [P_Requesters-1:0] rotated;
  logic [PtrW:0]           sum;

  // Rotate so bit 0 is the requester at ptr, find the first set bit, then rotate back.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rotated = P_Requesters'({eligible, eligible} >> ptr);
    offset  = '0;
    for (int k = P_Requesters - 1; k >= 0; k--) begin
      if (rotated[k]) offset = PtrW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (PtrW+1)'(P_Requesters)) sum = sum - (PtrW+1)'(P_Requesters);
    winner   = sum[PtrW-1:0];
    ptr_next = (winner == PtrW'(P_Requesters - 1)) ? '0 : winner + PtrW'(1);
  end
`else
  always_comb begin
    winner = '0;
    for (int k = P_Requesters - 1; k >= 0; k--) begin
      if (eligible[k]) winner = PtrW'(k);
    end
  end
`endif

  always_comb begin
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    for (int k = 0; k < P_Requesters; k++) begin
      if (winner == PtrW'(k)) begin
        win_onehot[k] = 1'b1;
        win_addr      = In_Address[k*P_RegWidth +: P_RegWidth];
        win_data      = In_Data[k*P_DataWidth +: P_DataWidth];
      end
    end
  end

  // A pending write is simply dropped on reset; all outputs return to zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge In_Clock) begin
    if (In_Reset) begin
      state       <= IDLE;
      Out_Grant   <= '0;
      Out_Address <= '0;
      Out_Enable  <= 1'b0;
      Out_Data    <= '0;
      Out_Busy    <= 1'b0;
`ifdef REGWRITE_ARB_RR_EN
      ptr         <= '0;
`endif
    end else if (|eligible) begin
      state       <= WRITE;
      Out_Grant   <= win_onehot;
      Out_Address <= win_addr;
      Out_Enable  <= 1'b1;
      Out_Data    <= win_data;
      Out_Busy    <= 1'b1;
`ifdef REGWRITE_ARB_RR_EN
      ptr         <= ptr_next;
`endif
    end else begin
      state       <= IDLE;
      Out_Grant   <= '0;
      Out_Address <= '0;
      Out_Enable  <= 1'b0;
      Out_Data    <= '0;
      Out_Busy    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Self-checking bench for register_write_arbiter: directed table, a 3-requester wrap sequence,
// and randomized traffic against a queue-free behavioural model. Honors REGWRITE_ARB_RR_EN.
module tb_register_write_arbiter;

  localparam int RW = 3;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int N3 = 3;
`ifdef REGWRITE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req;
  logic [N*RW-1:0]   addr;
  logic [N*DW-1:0]   data;
  logic [N-1:0]      grant;
  logic [RW-1:0]     o_addr;
  logic              en;
  logic [DW-1:0]     o_data;
  logic              busy;

  logic [N3-1:0]     req3;
  logic [N3*RW-1:0]  addr3;
  logic [N3*DW-1:0]  data3;
  logic [N3-1:0]     grant3;
  logic [RW-1:0]     o_addr3;
  logic              en3;
  logic [DW-1:0]     o_data3;
  logic              busy3;

  register_write_arbiter #(.P_RegWidth(RW), .P_DataWidth(DW), .P_Requesters(N)) dut (
    .In_Clock(clk), .In_Reset(rst), .In_Request(req), .In_Address(addr), .In_Data(data),
    .Out_Grant(grant), .Out_Address(o_addr), .Out_Enable(en), .Out_Data(o_data), .Out_Busy(busy)
  );

  register_write_arbiter #(.P_RegWidth(RW), .P_DataWidth(DW), .P_Requesters(N3)) dut3 (
    .In_Clock(clk), .In_Reset(rst), .In_Request(req3), .In_Address(addr3), .In_Data(data3),
    .Out_Grant(grant3), .Out_Address(o_addr3), .Out_Enable(en3), .Out_Data(o_data3), .Out_Busy(busy3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 4-requester instance: who is being written, and where priority starts.
  int           m_idx = -1;
  int           m_ptr = 0;
  logic [RW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic int pick(input logic [7:0] elig, input int start, input int n);
    int s;
    s = RR ? start : 0;
    for (int k = 0; k < n; k++) begin
      if (elig[(s + k) % n]) return (s + k) % n;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [7:0] elig;
    int w;
    if (rst) begin
      m_idx = -1;
      m_ptr = 0;
    end else begin
      elig = 8'(req);
      if (m_idx >= 0) elig[m_idx] = 1'b0;
      w = pick(elig, m_ptr, N);
      m_idx = w;
      if (w >= 0) begin
        m_ptr  = (w + 1) % N;
        m_addr = addr[w*RW +: RW];
        m_data = data[w*DW +: DW];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_fp;
  } vec_t;

  vec_t vecs[17];
  logic [RW-1:0] a_of[N];
  logic [DW-1:0] d_of[N];

  initial begin
    logic [N-1:0] eg;
    logic [RW-1:0] ea;
    logic [DW-1:0] ed;
    logic [N3-1:0] seq3[3];

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0010, 4'b0010};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0100, 4'b0001};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1000, 4'b0010};
    vecs[8]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
    vecs[9]  = '{1'b0, 4'b1111, 4'b0010, 4'b0010};
    vecs[10] = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
    vecs[11] = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
    vecs[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0000};
    vecs[13] = '{1'b0, 4'b0001, 4'b0001, 4'b0001};
    vecs[14] = '{1'b0, 4'b0001, 4'b0000, 4'b0000};
    vecs[15] = '{1'b0, 4'b0001, 4'b0001, 4'b0001};
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000};

    a_of = '{3'd1, 3'd3, 3'd5, 3'd7};
    d_of = '{8'h10, 8'h21, 8'hA5, 8'h3C};

    rst   = 1'b1;
    req   = '0;
    addr  = {a_of[3], a_of[2], a_of[1], a_of[0]};
    data  = {d_of[3], d_of[2], d_of[1], d_of[0]};
    req3  = '0;
    addr3 = {3'd6, 3'd4, 3'd2};
    data3 = {8'hC2, 8'hB1, 8'hA0};

    // Directed table on the 4-requester instance.
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      tick();
      eg = RR ? vecs[i].exp_rr : vecs[i].exp_fp;
      ea = '0;
      ed = '0;
      for (int k = 0; k < N; k++) begin
        if (eg[k]) begin
          ea = a_of[k];
          ed = d_of[k];
        end
      end
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(eg));
      check($sformatf("vec%0d enable", i), 32'(en), 32'(|eg));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(|eg));
      check($sformatf("vec%0d addr", i), 32'(o_addr), 32'(ea));
      check($sformatf("vec%0d data", i), 32'(o_data), 32'(ed));
    end

    // Three requesters: grant index 1 first so the pointer sits at 2, then all request.
    rst = 1'b1;
    req = '0;
    tick();
    rst  = 1'b0;
    req3 = 3'b010;
    tick();
    check("n3 first grant", 32'(grant3), 32'(3'b010));
    check("n3 first addr", 32'(o_addr3), 32'(3'd4));
    check("n3 first data", 32'(o_data3), 32'(8'hB1));
    req3 = 3'b000;
    tick();
    check("n3 idle", 32'({busy3, en3, grant3}), 32'(0));
    req3 = 3'b111;
    seq3 = RR ? '{3'b100, 3'b001, 3'b010} : '{3'b001, 3'b010, 3'b001};
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("n3 wrap %0d grant", i), 32'(grant3), 32'(seq3[i]));
      check($sformatf("n3 wrap %0d enable", i), 32'(en3), 32'(1));
    end
    req3 = '0;

    // Randomized traffic against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[k] = 1'b1;
            addr[k*RW +: RW] = 3'($urandom);
            data[k*DW +: DW] = 8'($urandom);
          end
        end else if (m_idx == k) begin
          if ($urandom_range(0, 1) == 0) begin
            req[k] = 1'b0;
          end else begin
            addr[k*RW +: RW] = 3'($urandom);
            data[k*DW +: DW] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      tick();
      eg = (m_idx >= 0) ? N'(1 << m_idx) : '0;
      check("rand grant", 32'(grant), 32'(eg));
      check("rand enable", 32'(en), 32'(m_idx >= 0));
      check("rand busy", 32'(busy), 32'(m_idx >= 0));
      check("rand addr", 32'(o_addr), (m_idx >= 0) ? 32'(m_addr) : 32'(0));
      check("rand data", 32'(o_data), (m_idx >= 0) ? 32'(m_data) : 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
